multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multicycle control FSM that sequences the RV32I datapath: instruction fetch, decode, execute, memory access and register writeback, one instruction at a time. It owns the instruction- and data-memory request/acknowledge handshakes. It drives the PC/IR write enables, ALU operand selects and the immediate-format select for the shared immediate generator. It also keeps a retired-instruction counter and traps on unsupported opcodes.

## Interface
Parameters:
- CNT_W, 32, width of the retired-instruction counter

Ports:
- clk  in  1  clock, all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- instr  in  32  current IR contents; valid from the cycle after ir_we
- branch_taken  in  1  datapath comparator result; valid in EXEC
- imem_req  out  1  instruction fetch request
- imem_ack  in  1  fetch data valid this cycle
- dmem_req  out  1  data memory request
- dmem_we  out  1  1 = store, 0 = load; valid while dmem_req is high
- dmem_ack  in  1  data access complete this cycle
- ir_we  out  1  load IR from fetch data; datapath latches old_pc on the same cycle
- pc_we  out  1  PC write enable
- pc_sel  out  1  0 = PC+4, 1 = alu_out (branch/jump target)
- alu_a_sel  out  2  00 = rs1, 01 = old_pc, 10 = zero
- alu_b_sel  out  1  0 = rs2, 1 = imm_val
- alu_op  out  2  00 = add, 01 = funct-decoded, 10 = compare
- imm_type  out  3  0 = I, 1 = S, 2 = B, 3 = U, 4 = J, 7 = none
- reg_we  out  1  register file write enable
- wb_sel  out  2  00 = alu_out, 01 = mem data, 10 = old_pc+4
- retire  out  1  one-cycle pulse on the final cycle of each instruction
- instret  out  CNT_W  retired-instruction count
- illegal  out  1  sticky trap flag

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP. Encoding is free.
- Output defaults: every select and enable is 0 in every state unless listed below. imm_type defaults to 7.
- FETCH:
  - imem_req = 1.
  - On imem_ack: ir_we = 1, pc_we = 1, pc_sel = 0, then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE:
  - Classify instr[6:0].
  - Supported opcodes: 0110011 R, 0010011 I, 0000011 LOAD, 0100011 STORE, 1100011 BRANCH, 1101111 JAL, 0110111 LUI, 0010111 AUIPC.
  - Any other opcode (including JALR 1100111) goes to TRAP.
  - imm_type is registered here from the opcode and held constant through the end of the instruction.
- EXEC (per class):
  - R: a = rs1, b = rs2, op = 01.
  - I: a = rs1, b = imm, op = 01.
  - LOAD / STORE: a = rs1, b = imm, op = 00.
  - LUI: a = zero, b = imm, op = 00.
  - AUIPC: a = old_pc, b = imm, op = 00.
  - BRANCH: op = 10. If branch_taken, pc_we = 1 and pc_sel = 1 (the datapath's target adder uses old_pc + imm_val). The instruction retires here.
  - JAL: a = old_pc, b = imm, op = 00, pc_we = 1, pc_sel = 1.
  - Next state: MEM for LOAD and STORE, FETCH for BRANCH, WB for everything else.
- MEM:
  - dmem_req = 1; dmem_we = 1 for STORE.
  - Hold until dmem_ack.
  - On ack: LOAD goes to WB; STORE retires and goes to FETCH.
- WB:
  - reg_we = 1, then go to FETCH.
  - wb_sel: 01 for LOAD, 10 for JAL, 00 otherwise.
- TRAP: illegal = 1. Absorbing state; only rst leaves it. No requests are issued.
- instret increments by 1 on every retire and wraps modulo 2^CNT_W.

## Timing
- Reset: state = FETCH and illegal = 0, instret = 0, imm_type = 7.
- Reset: all other outputs are 0, except imem_req, which rises in the first cycle after rst deasserts.
- Handshakes:
  - A req is held high until the ack is sampled. Ack may arrive in the same cycle req first rises, giving zero wait states.
  - An ack sampled while the corresponding req is low is ignored.
- Latency in cycles with zero-wait memory: BRANCH 3, STORE 4, R / I / LUI / AUIPC / JAL 4, LOAD 5. Each memory wait cycle adds 1.
- retire timing:
  - Asserted in the WB cycle, the EXEC cycle of a BRANCH, or the MEM ack cycle of a STORE.
  - The instret value is visible the following cycle.
- rst asserted in any state, including mid-MEM or mid-FETCH: req drops in the next cycle and the FSM returns to FETCH. No write enable is asserted in the rst cycle.

## Test plan
- addi x1,x0,5 (0x00500093), ack immediate -> states FETCH,DECODE,EXEC,WB. imm_type = 0, alu_b_sel = 1, reg_we in cycle 4, wb_sel = 00, instret goes 0 -> 1.
- lw x2,4(x1) (0x0040A103), dmem_ack delayed 3 cycles -> dmem_req high for 4 cycles with dmem_we = 0. WB follows with wb_sel = 01. Total 8 cycles.
- beq x0,x0,8 (0x00000463): branch_taken = 1 -> pc_we with pc_sel = 1 in EXEC and retire in cycle 3. Repeat with branch_taken = 0 -> no pc_we in EXEC.
- jal x1,16 (0x010000EF) -> imm_type = 4, pc_sel = 1 in EXEC. Then WB with reg_we = 1, wb_sel = 10.
- Fetch 0x00000000 -> TRAP with illegal = 1. No imem_req for 20 further cycles, instret unchanged. rst clears illegal and resumes FETCH.
- rst pulsed during the second wait cycle of a store MEM -> dmem_req = 0 the next cycle, no retire, FSM in FETCH, instret = 0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle RV32I control FSM with memory handshakes and retire counter
//
// Sequences one instruction at a time through FETCH, DECODE, EXEC, MEM and WB.
// Unsupported opcodes park the FSM in TRAP until rst.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   instr               current IR contents (valid from the cycle after ir_we)
//   branch_taken        datapath comparator result, sampled in EXEC
//   imem_req/imem_ack   instruction fetch handshake
//   dmem_req/dmem_we    data access request, 1 = store
//   dmem_ack            data access complete
//   ir_we, pc_we        IR and PC write enables
//   pc_sel              0 = PC+4, 1 = alu_out
//   alu_a_sel           00 = rs1, 01 = old_pc, 10 = zero
//   alu_b_sel           0 = rs2, 1 = imm_val
//   alu_op              00 = add, 01 = funct-decoded, 10 = compare
//   imm_type            0 = I, 1 = S, 2 = B, 3 = U, 4 = J, 7 = none
//   reg_we, wb_sel      register writeback enable and source select
//   retire              pulse on the final cycle of each instruction
//   instret             retired-instruction count
//   illegal             sticky trap flag

module multicycle_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      instr,
   input  logic             branch_taken,
   output logic             imem_req,
   input  logic             imem_ack,
   output logic             dmem_req,
   output logic             dmem_we,
   input  logic             dmem_ack,
   output logic             ir_we,
   output logic             pc_we,
   output logic             pc_sel,
   output logic [1:0]       alu_a_sel,
   output logic             alu_b_sel,
   output logic [1:0]       alu_op,
   output logic [2:0]       imm_type,
   output logic             reg_we,
   output logic [1:0]       wb_sel,
   output logic             retire,
   output logic [CNT_W-1:0] instret,
   output logic             illegal
);

   typedef enum logic [2:0] {
      FETCH,
      DECODE,
      EXEC,
      MEM,
      WB,
      TRAP
   } state_t;

   typedef enum logic [2:0] {
      C_R,
      C_I,
      C_LOAD,
      C_STORE,
      C_BRANCH,
      C_JAL,
      C_LUI,
      C_AUIPC
   } cls_t;

   localparam logic [2:0] IMM_I    = 3'd0;
   localparam logic [2:0] IMM_S    = 3'd1;
   localparam logic [2:0] IMM_B    = 3'd2;
   localparam logic [2:0] IMM_U    = 3'd3;
   localparam logic [2:0] IMM_J    = 3'd4;
   localparam logic [2:0] IMM_NONE = 3'd7;

   localparam logic [1:0] A_RS1   = 2'b00;
   localparam logic [1:0] A_PC    = 2'b01;
   localparam logic [1:0] A_ZERO  = 2'b10;

   localparam logic [1:0] OP_ADD  = 2'b00;
   localparam logic [1:0] OP_FUNC = 2'b01;
   localparam logic [1:0] OP_CMP  = 2'b10;

   localparam logic [1:0] WB_ALU  = 2'b00;
   localparam logic [1:0] WB_MEM  = 2'b01;
   localparam logic [1:0] WB_LINK = 2'b10;

   state_t           state, state_nx;
   cls_t             cls_q, cls_dec;
   logic             dec_ok;
   logic [2:0]       imm_q, imm_dec;
   logic [CNT_W-1:0] cnt_q;

   // Only the opcode field steers the controller; funct bits are decoded by the ALU.
   logic unused_instr_bits;
   assign unused_instr_bits = ^instr[31:7];

   // Opcode classification, used only while in DECODE.
   always_comb begin
      dec_ok  = 1'b1;
      cls_dec = C_R;
      imm_dec = IMM_NONE;
      case (instr[6:0])
         7'b0110011: begin cls_dec = C_R;      imm_dec = IMM_NONE; end
         7'b0010011: begin cls_dec = C_I;      imm_dec = IMM_I;    end
         7'b0000011: begin cls_dec = C_LOAD;   imm_dec = IMM_I;    end
         7'b0100011: begin cls_dec = C_STORE;  imm_dec = IMM_S;    end
         7'b1100011: begin cls_dec = C_BRANCH; imm_dec = IMM_B;    end
         7'b1101111: begin cls_dec = C_JAL;    imm_dec = IMM_J;    end
         7'b0110111: begin cls_dec = C_LUI;    imm_dec = IMM_U;    end
         7'b0010111: begin cls_dec = C_AUIPC;  imm_dec = IMM_U;    end
         default:    begin dec_ok = 1'b0;      imm_dec = IMM_NONE; end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= FETCH;
         cls_q <= C_R;
         imm_q <= IMM_NONE;
         cnt_q <= '0;
      end else begin
         state <= state_nx;
         // imm_type is latched at decode and released once the instruction retires,
         // so FETCH/DECODE of the next instruction always present "none".
         if (state == DECODE) begin
            cls_q <= cls_dec;
            imm_q <= imm_dec;
         end else if (retire) begin
            imm_q <= IMM_NONE;
         end
         if (retire) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

   assign instret = cnt_q;

   // Every output is forced idle while rst is high so that no request or
   // write enable escapes from whatever state the FSM was in.
   always_comb begin
      state_nx  = state;
      imem_req  = 1'b0;
      dmem_req  = 1'b0;
      dmem_we   = 1'b0;
      ir_we     = 1'b0;
      pc_we     = 1'b0;
      pc_sel    = 1'b0;
      alu_a_sel = A_RS1;
      alu_b_sel = 1'b0;
      alu_op    = OP_ADD;
      imm_type  = IMM_NONE;
      reg_we    = 1'b0;
      wb_sel    = WB_ALU;
      retire    = 1'b0;
      illegal   = 1'b0;

      if (!rst) begin
         imm_type = imm_q;
         case (state)
            FETCH: begin
               imem_req = 1'b1;
               if (imem_ack) begin
                  ir_we    = 1'b1;
                  pc_we    = 1'b1;
                  pc_sel   = 1'b0;
                  state_nx = DECODE;
               end
            end

            DECODE: begin
               state_nx = dec_ok ? EXEC : TRAP;
            end

            EXEC: begin
               state_nx = WB;
               case (cls_q)
                  C_R: begin
                     alu_a_sel = A_RS1;
                     alu_b_sel = 1'b0;
                     alu_op    = OP_FUNC;
                  end
                  C_I: begin
                     alu_a_sel = A_RS1;
                     alu_b_sel = 1'b1;
                     alu_op    = OP_FUNC;
                  end
                  C_LOAD, C_STORE: begin
                     alu_a_sel = A_RS1;
                     alu_b_sel = 1'b1;
                     alu_op    = OP_ADD;
                     state_nx  = MEM;
                  end
                  C_LUI: begin
                     alu_a_sel = A_ZERO;
                     alu_b_sel = 1'b1;
                     alu_op    = OP_ADD;
                  end
                  C_AUIPC: begin
                     alu_a_sel = A_PC;
                     alu_b_sel = 1'b1;
                     alu_op    = OP_ADD;
                  end
                  C_BRANCH: begin
                     // The ALU compares rs1/rs2 while the datapath's own adder
                     // forms old_pc + imm_val for the taken target.
                     alu_op   = OP_CMP;
                     pc_we    = branch_taken;
                     pc_sel   = branch_taken;
                     retire   = 1'b1;
                     state_nx = FETCH;
                  end
                  C_JAL: begin
                     alu_a_sel = A_PC;
                     alu_b_sel = 1'b1;
                     alu_op    = OP_ADD;
                     pc_we     = 1'b1;
                     pc_sel    = 1'b1;
                  end
                  default: begin
                     state_nx = WB;
                  end
               endcase
            end

            MEM: begin
               dmem_req = 1'b1;
               dmem_we  = (cls_q == C_STORE);
               if (dmem_ack) begin
                  if (cls_q == C_STORE) begin
                     retire   = 1'b1;
                     state_nx = FETCH;
                  end else begin
                     state_nx = WB;
                  end
               end
            end

            WB: begin
               reg_we   = 1'b1;
               retire   = 1'b1;
               state_nx = FETCH;
               case (cls_q)
                  C_LOAD:  wb_sel = WB_MEM;
                  C_JAL:   wb_sel = WB_LINK;
                  default: wb_sel = WB_ALU;
               endcase
            end

            TRAP: begin
               illegal  = 1'b1;
               state_nx = TRAP;
            end

            default: begin
               state_nx = FETCH;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - self-checking bench for multicycle_ctrl against a per-instruction phase model

module tb_multicycle_ctrl;

   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic [31:0]      instr;
   logic             branch_taken;
   logic             imem_req;
   logic             imem_ack;
   logic             dmem_req;
   logic             dmem_we;
   logic             dmem_ack;
   logic             ir_we;
   logic             pc_we;
   logic             pc_sel;
   logic [1:0]       alu_a_sel;
   logic             alu_b_sel;
   logic [1:0]       alu_op;
   logic [2:0]       imm_type;
   logic             reg_we;
   logic [1:0]       wb_sel;
   logic             retire;
   logic [CNT_W-1:0] instret;
   logic             illegal;

   multicycle_ctrl #(.CNT_W(CNT_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .instr        (instr),
      .branch_taken (branch_taken),
      .imem_req     (imem_req),
      .imem_ack     (imem_ack),
      .dmem_req     (dmem_req),
      .dmem_we      (dmem_we),
      .dmem_ack     (dmem_ack),
      .ir_we        (ir_we),
      .pc_we        (pc_we),
      .pc_sel       (pc_sel),
      .alu_a_sel    (alu_a_sel),
      .alu_b_sel    (alu_b_sel),
      .alu_op       (alu_op),
      .imm_type     (imm_type),
      .reg_we       (reg_we),
      .wb_sel       (wb_sel),
      .retire       (retire),
      .instret      (instret),
      .illegal      (illegal)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       imem_req;
      logic       dmem_req;
      logic       dmem_we;
      logic       ir_we;
      logic       pc_we;
      logic       pc_sel;
      logic [1:0] a_sel;
      logic       b_sel;
      logic [1:0] op;
      logic [2:0] imm;
      logic       reg_we;
      logic [1:0] wb;
      logic       retire;
      logic       illegal;
   } outs_t;

   int passed  = 0;
   int total   = 0;
   int retired = 0;

   function automatic outs_t idle_outs();
      outs_t e;
      e     = '0;
      e.imm = 3'd7;
      return e;
   endfunction

   function automatic outs_t observed();
      outs_t o;
      o.imem_req = imem_req;
      o.dmem_req = dmem_req;
      o.dmem_we  = dmem_we;
      o.ir_we    = ir_we;
      o.pc_we    = pc_we;
      o.pc_sel   = pc_sel;
      o.a_sel    = alu_a_sel;
      o.b_sel    = alu_b_sel;
      o.op       = alu_op;
      o.imm      = imm_type;
      o.reg_we   = reg_we;
      o.wb       = wb_sel;
      o.retire   = retire;
      o.illegal  = illegal;
      return o;
   endfunction

   // Compare one cycle of outputs (and optionally instret), then advance to the next negedge.
   task automatic step(input outs_t e, input bit chk_cnt, input string tag);
      logic [CNT_W-1:0] want_cnt;
      outs_t            o;
      #1;
      o = observed();
      total++;
      assert (o === e) begin
         passed++;
      end else begin
         $error("FAIL %s outputs observed=%h expected=%h", tag, o, e);
      end
      if (chk_cnt) begin
         want_cnt = CNT_W'(retired % (1 << CNT_W));
         total++;
         assert (instret === want_cnt) begin
            passed++;
         end else begin
            $error("FAIL %s instret observed=%0d expected=%0d", tag, instret, want_cnt);
         end
      end
      if (e.retire) retired++;
      @(posedge clk);
      @(negedge clk);
   endtask

   // Acks and branch_taken outside their live window must be ignored, so they are randomized.
   task automatic noise();
      imem_ack     = 1'($urandom_range(0, 1));
      dmem_ack     = 1'($urandom_range(0, 1));
      branch_taken = 1'($urandom_range(0, 1));
   endtask

   task automatic do_reset(input int n);
      rst      = 1'b1;
      imem_ack = 1'b1;
      dmem_ack = 1'b1;
      for (int i = 0; i < n; i++) step(idle_outs(), 1'b0, "reset");
      rst     = 1'b0;
      retired = 0;
   endtask

   // Expected behaviour of one instruction, derived phase by phase from the opcode class.
   task automatic run_instr(input logic [31:0] ins, input int fw, input int mw,
                            input bit bt, input int rst_mem, input string tag);
      outs_t      e;
      logic [6:0] opc;
      bit         legal, is_mem, is_store, is_branch;
      logic [2:0] imm;
      opc       = ins[6:0];
      legal     = 1'b1;
      imm       = 3'd7;
      is_mem    = (opc == 7'h03) || (opc == 7'h23);
      is_store  = (opc == 7'h23);
      is_branch = (opc == 7'h63);
      case (opc)
         7'h33:   imm = 3'd7;
         7'h13:   imm = 3'd0;
         7'h03:   imm = 3'd0;
         7'h23:   imm = 3'd1;
         7'h63:   imm = 3'd2;
         7'h6F:   imm = 3'd4;
         7'h37:   imm = 3'd3;
         7'h17:   imm = 3'd3;
         default: legal = 1'b0;
      endcase

      for (int i = 0; i <= fw; i++) begin
         noise();
         imem_ack   = (i == fw);
         e          = idle_outs();
         e.imem_req = 1'b1;
         e.ir_we    = (i == fw);
         e.pc_we    = (i == fw);
         step(e, 1'b1, {tag, "/fetch"});
      end

      instr = ins;
      noise();
      step(idle_outs(), 1'b1, {tag, "/decode"});

      if (!legal) begin
         for (int i = 0; i < 20; i++) begin
            noise();
            e         = idle_outs();
            e.illegal = 1'b1;
            step(e, 1'b1, {tag, "/trap"});
         end
         return;
      end

      noise();
      branch_taken = bt;
      e     = idle_outs();
      e.imm = imm;
      case (opc)
         7'h33: begin e.a_sel = 2'b00; e.b_sel = 1'b0; e.op = 2'b01; end
         7'h13: begin e.a_sel = 2'b00; e.b_sel = 1'b1; e.op = 2'b01; end
         7'h03,
         7'h23: begin e.a_sel = 2'b00; e.b_sel = 1'b1; e.op = 2'b00; end
         7'h37: begin e.a_sel = 2'b10; e.b_sel = 1'b1; e.op = 2'b00; end
         7'h17: begin e.a_sel = 2'b01; e.b_sel = 1'b1; e.op = 2'b00; end
         7'h63: begin e.op = 2'b10; e.pc_we = bt; e.pc_sel = bt; e.retire = 1'b1; end
         7'h6F: begin e.a_sel = 2'b01; e.b_sel = 1'b1; e.op = 2'b00; e.pc_we = 1'b1; e.pc_sel = 1'b1; end
         default: ;
      endcase
      step(e, 1'b1, {tag, "/exec"});
      if (is_branch) return;

      if (is_mem) begin
         for (int j = 0; j <= mw; j++) begin
            noise();
            dmem_ack = (j == mw);
            if (j == rst_mem) begin
               rst      = 1'b1;
               dmem_ack = 1'b0;
               step(idle_outs(), 1'b0, {tag, "/rst"});
               rst     = 1'b0;
               retired = 0;
               return;
            end
            e          = idle_outs();
            e.imm      = imm;
            e.dmem_req = 1'b1;
            e.dmem_we  = is_store;
            e.retire   = is_store && (j == mw);
            step(e, 1'b1, {tag, "/mem"});
         end
         if (is_store) return;
      end

      noise();
      e        = idle_outs();
      e.imm    = imm;
      e.reg_we = 1'b1;
      e.retire = 1'b1;
      e.wb     = (opc == 7'h03) ? 2'b01 : (opc == 7'h6F) ? 2'b10 : 2'b00;
      step(e, 1'b1, {tag, "/wb"});
   endtask

   logic [6:0] ops [8] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17};

   initial begin
      logic [31:0] r;
      rst          = 1'b1;
      instr        = 32'h0;
      imem_ack     = 1'b0;
      dmem_ack     = 1'b0;
      branch_taken = 1'b0;

      do_reset(2);

      run_instr(32'h00500093, 0, 0, 1'b0, -1, "addi");
      run_instr(32'h0040A103, 0, 3, 1'b0, -1, "lw_wait3");
      run_instr(32'h00000463, 0, 0, 1'b1, -1, "beq_taken");
      run_instr(32'h00000463, 1, 0, 1'b0, -1, "beq_not_taken");
      run_instr(32'h010000EF, 0, 0, 1'b0, -1, "jal");
      run_instr(32'h0020A223, 0, 0, 1'b0, -1, "sw_zero_wait");
      run_instr(32'h123450B7, 2, 0, 1'b0, -1, "lui");
      run_instr(32'h00001097, 0, 0, 1'b0, -1, "auipc");
      run_instr(32'h002081B3, 0, 0, 1'b0, -1, "add");

      // Random program long enough to wrap the 4-bit counter several times.
      for (int n = 0; n < 60; n++) begin
         r = $urandom();
         run_instr({r[31:7], ops[$urandom_range(0, 7)]}, $urandom_range(0, 2),
                   $urandom_range(0, 3), 1'($urandom_range(0, 1)), -1, "rand");
      end

      run_instr(32'h0020A223, 0, 5, 1'b0, 1, "sw_rst_mid_mem");
      run_instr(32'h00500093, 0, 0, 1'b0, -1, "addi_after_rst");

      run_instr(32'h00000000, 0, 0, 1'b0, -1, "illegal_zero");
      do_reset(1);
      run_instr(32'h00500093, 1, 0, 1'b0, -1, "addi_after_trap");

      run_instr(32'h000080E7, 0, 0, 1'b0, -1, "jalr_trap");
      do_reset(1);
      run_instr(32'h0040A103, 0, 0, 1'b0, -1, "lw_after_trap");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
